// File: rtl/aes_block_serializer.sv
// Drains 128-bit AES-CTR blocks into an OUT_W-bit word stream, most-significant word first.
// Optional build macro AES_SER_BYTE_SWAP_EN byte-reverses each output word for little-endian buses.
module aes_block_serializer #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [127:0]     in_block,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    // state | meaning
    // IDLE  | no block held; ready for a new block
    // SEND  | emitting word idx of the held block

    localparam int NWORDS = 128 / OUT_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [127:0]       blk_buf, blk_buf_nxt;
    logic               last_flag, last_flag_nxt;

    logic               at_last;
    logic               blk_acc;
    logic               word_xfer;
    logic [OUT_W-1:0]   words [NWORDS];
    logic [OUT_W-1:0]   word_sel;
    logic [OUT_W-1:0]   word_out;

    assign at_last   = (idx == LAST_IDX);
    // The only combinational input-to-output path: out_ready opens the slot for a back-to-back block.
    assign in_ready  = (state == IDLE) || (at_last && out_ready);
    assign blk_acc   = in_valid && in_ready;
    assign word_xfer = (state == SEND) && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            blk_buf   <= '0;
            last_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            blk_buf   <= blk_buf_nxt;
            last_flag <= last_flag_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        blk_buf_nxt   = blk_buf;
        last_flag_nxt = last_flag;
        case (state)
            IDLE: begin
                if (blk_acc) begin
                    blk_buf_nxt   = in_block;
                    last_flag_nxt = in_last;
                    idx_nxt       = '0;
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                if (word_xfer) begin
                    if (!at_last) begin
                        idx_nxt = idx + 1'b1;
                    end else if (blk_acc) begin
                        blk_buf_nxt   = in_block;
                        last_flag_nxt = in_last;
                        idx_nxt       = '0;
                    end else begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    for (genvar w = 0; w < NWORDS; w++) begin : g_words
        assign words[w] = blk_buf[127 - w*OUT_W -: OUT_W];
    end

    assign word_sel = words[idx];

`ifdef AES_SER_BYTE_SWAP_EN
    for (genvar b = 0; b < OUT_W/8; b++) begin : g_swap
        assign word_out[8*b +: 8] = word_sel[OUT_W-8-8*b +: 8];
    end
`else
    assign word_out = word_sel;
`endif

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_data  = (state == SEND) ? word_out : '0;
    assign out_last  = (state == SEND) && last_flag && at_last;

endmodule

// File: doc/aes_block_serializer.md
Name: aes_block_serializer

Overview:
- Drains 128-bit AES-CTR output blocks (ciphertext or keystream) into a narrower word stream for the video output path. This is the reader side of the 128-bit block registers.
- Accepts one block per valid/ready handshake, holds it in an internal buffer, and emits it most-significant word first over a valid/ready interface.
- Back-to-back blocks stream with no bubble.

Parameters:
- OUT_W, 32, output word width in bits. Legal values are 8, 16, 32 and 64; each divides 128.
- NWORDS, 128/OUT_W, words per block. This is derived and must not be overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset; clears all state
- in_block  in  128  block to serialize; bits 127:0
- in_last  in  1  block is the final block of a video frame
- in_valid  in  1  in_block and in_last are valid
- in_ready  out  1  serializer can accept a block this cycle
- out_data  out  OUT_W  current output word
- out_last  out  1  final word of a block tagged in_last
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts out_data this cycle
- busy  out  1  a block is held, or is being emitted

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state to IDLE, word index to 0, buffer to 128'b0, the last flag to 0;
  - out_valid=0, out_last=0, out_data=0, busy=0, in_ready=1.
- A reset asserted mid-block discards the partial block. No further words of that block are emitted after reset releases.
- Block handshake: a block is accepted on a rising edge where in_valid and in_ready are both 1.
- Word handshake: a word transfers on a rising edge where out_valid and out_ready are both 1.
- State IDLE:
  - out_valid=0, in_ready=1.
  - On block accept: load the buffer with in_block, the last flag with in_last, set idx=0, go to SEND.
- State SEND:
  - out_valid=1.
  - out_data = buffer[127-idx*OUT_W -: OUT_W], so word 0 is bits 127:(128-OUT_W).
  - out_last = last flag AND (idx==NWORDS-1).
  - On a word transfer with idx<NWORDS-1: idx increments and the state stays SEND.
  - On a word transfer with idx==NWORDS-1, with a block accepted in the same cycle: reload the buffer, idx=0, stay in SEND (zero-bubble back-to-back).
  - On a word transfer with idx==NWORDS-1, with no block accepted: go to IDLE, idx=0.
- in_ready = (state==IDLE) OR (state==SEND AND idx==NWORDS-1 AND out_ready).
  - This is combinational from out_ready.
  - No other combinational input-to-output paths exist.
- While out_ready=0, out_data, out_last and out_valid hold stable. in_valid without in_ready has no effect, and input values are not sampled.
- busy=1 exactly when state==SEND.
- Latency: the first word of a block is valid on the cycle after acceptance. A block occupies exactly NWORDS output transfers.
- Sustained throughput is 1 word/clk when out_ready is held at 1.
- idx is a $clog2(NWORDS)-bit counter. It never exceeds NWORDS-1, and wrap-around happens only through the reload/IDLE rules above.
- With OUT_W=8, NWORDS=16: the behaviour is the same, with 16 transfers per block.

Optional Feature:
- Macro: AES_SER_BYTE_SWAP_EN.
- When defined: each output word is byte-reversed before driving out_data. Example with OUT_W=32: buffer word 0x00112233 is driven as 0x33221100. This matches little-endian pixel buses. Word order within the block is unchanged (most-significant word first).
- For OUT_W=8 the swap is a no-op.
- When undefined: out_data is the buffer slice unmodified, and no swap logic is synthesized.
- Handshake and timing are identical in both builds.

Test Plan:
- Single block, OUT_W=32:
  - Stimulus: in_block=0x00112233_44556677_8899AABB_CCDDEEFF, in_last=0, out_ready held 1.
  - Required: words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles, starting the cycle after accept; out_last=0 throughout; then out_valid=0 and busy=0.
- Back-to-back:
  - Stimulus: blocks A then B with in_valid held 1 and out_ready=1.
  - Required: in_ready=1 only in the cycle of A's 4th word; B's word 0 appears the next cycle; 8 words over 8 consecutive cycles with no gap.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,0,1,1 during a block.
  - Required: out_data holds during out_ready=0 cycles; exactly 4 transfers in order; in_ready=0 while idx<3.
- Frame end:
  - Stimulus: block with in_last=1.
  - Required: out_last=1 only on word 3 (0xCCDDEEFF), 0 on words 0–2.
- Reset mid-block:
  - Stimulus: assert reset asynchronously (between clock edges) after word 1 transfers.
  - Required: out_valid=0, busy=0, in_ready=1 immediately; after release, no residual words; a new block 0xFFFF…FFFF emits 4 words of 0xFFFFFFFF.
- Feature build:
  - Stimulus: AES_SER_BYTE_SWAP_EN defined, first test's block.
  - Required: 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC.
